// File: rtl/dmem_pkg.sv
// Shared definitions for byte_data_memory and its lane-alignment helper.
//   - access size encodings carried on the size port
//   - sweep FSM state type
//   - is_aligned(): legality check for a size / byte-lane pair
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Halves must sit on an even byte and words on lane 0; the reserved size is never legal.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for byte_data_memory.
//   Store side: byte enables and lane-replicated write word from size/lane/wdata.
//   Load side:  extracts the addressed byte/half from the read word and extends it.
// Ports:
//   size        in  2   access size (SZ_* encoding)
//   lane        in  2   byte address bits [1:0]
//   unsigned_ld in  1   zero-extend byte/half loads
//   wdata       in  32  right-justified store data
//   rword       in  32  word read from the array
//   be          out 4   per-lane write enables (0 for the reserved size)
//   wword       out 32  store data replicated onto every lane
//   ldata       out 32  extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the data onto all lanes lets the enables alone pick the destination.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        case (size)
            SZ_BYTE: begin
                wword = {4{wdata[7:0]}};
                case (lane)
                    2'd0:    be = 4'b0001;
                    2'd1:    be = 4'b0010;
                    2'd2:    be = 4'b0100;
                    default: be = 4'b1000;
                endcase
            end
            SZ_HALF: begin
                wword = {2{wdata[15:0]}};
                be    = lane[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    ld_byte = rword[7:0];
            2'd1:    ld_byte = rword[15:8];
            2'd2:    ld_byte = rword[23:16];
            default: ld_byte = rword[31:24];
        endcase
        ld_half = lane[1] ? rword[31:16] : rword[15:0];

        case (size)
            SZ_BYTE: ldata = unsigned_ld ? {24'h000000, ld_byte}
                                         : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ldata = unsigned_ld ? {16'h0000, ld_half}
                                         : {{16{ld_half[15]}}, ld_half};
            default: ldata = rword;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed data memory for the MIPS MEM stage.
// Supports SB/SH/SW stores and LB/LBU/LH/LHU/LW loads, rejects misaligned accesses,
// returns loads one cycle after acceptance, and zeroes the array with a multi-cycle sweep
// (after reset when CLEAR_ON_RESET=1, and on every clear pulse while idle).
// Ports:
//   clk         in  1       rising-edge clock
//   reset       in  1       asynchronous active-low reset
//   req         in  1       access request, accepted when busy=0 and no clear pulse
//   we          in  1       1 store, 0 load
//   size        in  2       00 byte, 01 half, 10 word, 11 reserved
//   unsigned_ld in  1       zero-extend byte/half loads
//   addr        in  ADDR_W  byte address
//   wdata       in  32      right-justified store data
//   clear       in  1       pulse: start a zeroing sweep
//   rdata       out 32      registered load result, holds between loads
//   rvalid      out 1       pulse: rdata updated by a load
//   misalign    out 1       pulse: access rejected
//   busy        out 1       sweep in progress
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH          = 1024,
    parameter  bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned ADDR_W         = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              clear,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              misalign,
    output logic              busy
);

    localparam int unsigned      IDX_W    = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sweep_we;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             accept, aligned, do_store, do_load, reject;
    logic [3:0]       be;
    logic [31:0]      wword, rword, ldata;

    logic [31:0]      rdata_q;
    logic             rvalid_q, misalign_q;

    assign word_idx = addr[ADDR_W-1:2];
    assign lane     = addr[1:0];

    // A clear pulse in IDLE takes priority and silently drops a coincident request.
    assign accept   = req & ~busy & ~clear;
    assign aligned  = is_aligned(size, lane);
    assign do_store = accept &  we & aligned;
    assign do_load  = accept & ~we & aligned;
    assign reject   = accept & ~aligned;

    // ---------------- sweep FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- sweep FSM: next state ----------------
    // A clear pulse during CLEAR is ignored so the sweep length is never extended.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- sweep FSM: outputs ----------------
    always_comb begin
        busy     = (state_q == ST_CLEAR);
        sweep_we = (state_q == ST_CLEAR);
    end

    // ---------------- lane steering ----------------
    dmem_lane_align u_lane_align (
        .size        (size),
        .lane        (lane),
        .unsigned_ld (unsigned_ld),
        .wdata       (wdata),
        .rword       (rword),
        .be          (be),
        .wword       (wword),
        .ldata       (ldata)
    );

    // ---------------- storage (never reset directly) ----------------
    assign rword = mem[word_idx];

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q] <= 32'h0000_0000;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q    <= 32'h0000_0000;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rvalid_q   <= do_load;
            misalign_q <= reject;
            if (do_load) begin
                rdata_q <= ldata;
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;

endmodule

// File: doc/byte_data_memory.md
Name: byte_data_memory

Overview:
- Parametrised successor to the word-only data memory for the MIPS datapath; sits between the MEM stage and the load/store unit.
- Adds byte-addressed SB/SH/SW stores and LB/LBU/LH/LHU/LW loads with sign or zero extension.
- Adds alignment checking, a registered read with a valid strobe, and a multi-cycle clear sweep that replaces the single-cycle reset clear.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, at least 4.
- CLEAR_ON_RESET, 1: 1 runs a clear sweep after reset; 0 comes out of reset idle with array contents undefined.
- ADDR_W, derived as log2(DEPTH)+2: byte address width. Local parameter, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; accepted when req=1 and busy=0.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  in  1  1 = zero-extend loads (LBU/LHU); ignored for stores and words.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified.
- clear  in  1  one-cycle pulse; starts a zeroing sweep.
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle pulse, load result valid.
- misalign  out  1  one-cycle pulse, rejected access.
- busy  out  1  sweep in progress; requests are ignored.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - rdata=0, rvalid=0, misalign=0, sweep counter=0.
  - State CLEAR with busy=1 if CLEAR_ON_RESET=1; otherwise state IDLE with busy=0.
- The array is never reset directly.
- States:
  - CLEAR: writes 0 to word[cnt], cnt++ each cycle. After writing word DEPTH-1, go to IDLE the next edge. Busy is high for exactly DEPTH cycles after reset release.
  - IDLE: on a clear pulse, go to CLEAR with cnt=0.
- Precedence and interruption:
  - clear and req in the same IDLE cycle: clear wins, req is dropped with no response.
  - clear while in CLEAR: ignored; the sweep does not restart.
  - reset mid-sweep: the sweep restarts from word 0.
- Address split: word index = addr[ADDR_W-1:2]; lane = addr[1:0]; little-endian, lane 0 = bits 7:0.
- Alignment:
  - half requires addr[0]=0.
  - word requires addr[1:0]=00.
  - size=11 is always rejected.
- Rejected access:
  - No array write.
  - misalign pulses on the edge after acceptance; rvalid stays 0; rdata holds.
- Store:
  - byte writes wdata[7:0] into the addressed lane.
  - half writes wdata[15:0] into lanes {1,0} or {3,2}.
  - word writes all lanes.
  - Other lanes are unchanged. The array is written on the accept edge. No rvalid pulse.
- Load:
  - Word is read from the array on the accept edge.
  - rdata and rvalid=1 appear after that edge (latency 1). rvalid falls the next cycle unless another load is accepted.
  - rdata holds until the next accepted load.
  - Byte/half results are sign-extended unless unsigned_ld=1.
- Back-to-back: one access per cycle. A load accepted the cycle after a store to the same word returns the new data; there is no same-edge forwarding needed.
- Address bits above DEPTH cannot exist because ADDR_W is derived; there is no wrap logic.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - the state enum {ST_IDLE, ST_CLEAR};
  - an alignment-check function.
- One combinational sub-module, dmem_lane_align:
  - store side: builds the 4-bit byte-enable and lane-shifted write word from size/addr[1:0]/wdata;
  - load side: extracts and extends from the read word.
- The top holds the array, the FSM and the output registers.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1; hold reset low 2 cycles, release -> busy=1 for exactly 16 cycles; a req during busy is ignored; then LW addr 0x3C -> rdata=0x00000000, rvalid 1 cycle.
- SW 0xCAFEBABE @0x3C; LB @0x3C -> 0xFFFFFFBE; LBU @0x3F -> 0x000000CA; LH @0x3E -> 0xFFFFCAFE; LHU @0x3C -> 0x0000BABE.
- SW 0x12345678 @0x10; SB 0xAA @0x11; SH 0xBEEF @0x12; LW @0x10 -> 0xBEEFAA78.
- LH @0x01, LW @0x06, size=11 @0x00 -> each gives misalign=1 one cycle later, rvalid=0; a following LW @0x00 shows the array unchanged.
- Write nonzero data; pulse clear together with req=1 -> request dropped, busy for 16 cycles; a second clear mid-sweep does not extend busy; all words read back 0.
- Assert reset at sweep count 7 -> outputs zeroed immediately, sweep restarts, busy 16 cycles after release; CLEAR_ON_RESET=0 build -> busy=0 right after reset.
